// File: rtl/sram_write_drain.sv
// Drains the CPU pixel-write FIFO into an asynchronous SRAM, interleaved with video reads
// that have bounded-burst priority. Define SRAM_DRAIN_WRITE_COUNT_EN to build write_count.
module sram_write_drain #(
  parameter int MAX_READ_BURST = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fifo_empty,
  input  logic [16:0] fifo_addr,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  input  logic        vid_req,
  input  logic [16:0] vid_addr,
  output logic        vid_grant,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  output logic [16:0] sram_addr,
  output logic [7:0]  sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [7:0]  sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [15:0] write_count
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_READ_BURST);

  typedef enum logic [2:0] {
    IDLE, ARM, POP, W_SETUP, W_PULSE, W_HOLD, R_ADDR, R_SAMPLE
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] burst_cnt;
  logic       active;
  logic       read_sel;

  // active stays low while reset is held so no grant leaks out of the reset state.
  assign read_sel = vid_req && (fifo_empty || (burst_cnt < BURST_MAX));

  always_comb begin
    next_state = state;
    vid_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (active && read_sel) begin
          vid_grant  = 1'b1;
          next_state = R_ADDR;
        end else if (active && !fifo_empty) begin
          next_state = ARM;
        end
      end
      ARM:      next_state = POP;
      POP:      next_state = W_SETUP;
      W_SETUP:  next_state = W_PULSE;
      W_PULSE:  next_state = W_HOLD;
      W_HOLD:   next_state = IDLE;
      R_ADDR:   next_state = R_SAMPLE;
      R_SAMPLE: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      active    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state  <= next_state;
      active <= 1'b1;
      if (state == W_HOLD || (state == IDLE && fifo_empty)) begin
        burst_cnt <= '0;
      end else if (vid_grant && burst_cnt < BURST_MAX) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

  // Strobes are registered from next_state so the SRAM pins never glitch on decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      fifo_rd_en <= 1'b0;
    end else begin
      sram_ce_n  <= !(next_state inside {W_SETUP, W_PULSE, W_HOLD, R_ADDR, R_SAMPLE});
      sram_oe_n  <= !(next_state inside {R_ADDR, R_SAMPLE});
      sram_we_n  <= (next_state != W_PULSE);
      sram_dq_oe <= (next_state inside {W_SETUP, W_PULSE, W_HOLD});
      fifo_rd_en <= (next_state == POP);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      vid_data    <= '0;
      vid_valid   <= 1'b0;
    end else begin
      if (state == POP) begin
        sram_addr   <= fifo_addr;
        sram_dq_out <= fifo_data;
      end else if (vid_grant) begin
        sram_addr <= vid_addr;
      end
      vid_valid <= (state == R_SAMPLE);
      if (state == R_SAMPLE) begin
        vid_data <= sram_dq_in;
      end
    end
  end

`ifdef SRAM_DRAIN_WRITE_COUNT_EN
  logic [15:0] write_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_cnt <= '0;
    end else if (state == W_HOLD) begin
      write_cnt <= write_cnt + 16'd1;
    end
  end

  assign write_count = write_cnt;
`else
  assign write_count = '0;
`endif

endmodule

// File: tb/tb_sram_write_drain.sv
// Directed bench for sram_write_drain with a small FIFO model whose empty flag lags by a cycle.
module tb_sram_write_drain;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fifo_empty;
  logic [16:0] fifo_addr;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        vid_req = 1'b0;
  logic [16:0] vid_addr = '0;
  logic        vid_grant;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic [16:0] sram_addr;
  logic [7:0]  sram_dq_out;
  logic        sram_dq_oe;
  logic [7:0]  sram_dq_in = '0;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [15:0] write_count;

  int tests = 0;
  int fails = 0;
  int exp_writes = 0;
  int bus_conflicts = 0;

  logic [16:0] mem_addr [64];
  logic [7:0]  mem_data [64];
  logic [5:0]  wr_ptr = '0;
  logic [5:0]  rd_ptr;

  always #5 clk = ~clk;

  sram_write_drain #(.MAX_READ_BURST(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .fifo_empty(fifo_empty), .fifo_addr(fifo_addr), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_grant(vid_grant),
    .vid_data(vid_data), .vid_valid(vid_valid),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .write_count(write_count)
  );

  // FIFO model: registered head, empty flag one cycle behind the pointers, cleared by reset.
  assign fifo_addr = mem_addr[rd_ptr];
  assign fifo_data = mem_data[rd_ptr];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= wr_ptr;
      fifo_empty <= 1'b1;
    end else begin
      fifo_empty <= (wr_ptr == rd_ptr);
      if (fifo_rd_en) rd_ptr <= rd_ptr + 6'd1;
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1 && sram_dq_oe === 1'b1 && sram_oe_n === 1'b0) bus_conflicts++;
  end

  task automatic push(input logic [16:0] a, input logic [7:0] d);
    mem_addr[wr_ptr] = a;
    mem_data[wr_ptr] = d;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  function automatic logic [15:0] exp_count();
`ifdef SRAM_DRAIN_WRITE_COUNT_EN
    return 16'(exp_writes);
`else
    return 16'h0;
`endif
  endfunction

  task automatic test_reset;
    vid_req = 1'b1;
    vid_addr = 17'h1FFFF;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      fails++;
      $display("FAIL reset_strobes: ce_n,oe_n,we_n,dq_oe=%b%b%b%b required 1110",
               sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe);
    end
    tests++;
    if (sram_addr !== 17'h0 || sram_dq_out !== 8'h0) begin
      fails++;
      $display("FAIL reset_bus: addr=%h dq_out=%h required 0/0", sram_addr, sram_dq_out);
    end
    tests++;
    if ({fifo_rd_en, vid_grant, vid_valid} !== 3'b000 || vid_data !== 8'h0) begin
      fails++;
      $display("FAIL reset_ctrl: rd_en,grant,valid=%b%b%b vid_data=%h required 000/00",
               fifo_rd_en, vid_grant, vid_valid, vid_data);
    end
    tests++;
    if (write_count !== 16'h0) begin
      fails++;
      $display("FAIL reset_write_count: got %h required 0000", write_count);
    end
    vid_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (sram_ce_n !== 1'b1 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: ce_n=%b rd_en=%b required 1/0", sram_ce_n, fifo_rd_en);
    end
  endtask

  task automatic test_single_write(input logic [16:0] a, input logic [7:0] d);
    int rd_idx, we_idx, ce_first, rd_cnt, we_cnt, ce_cnt, conf0;
    logic [16:0] a_w;
    logic [7:0]  d_w;
    logic        oe_w;
    rd_idx = -1; we_idx = -1; ce_first = -1; rd_cnt = 0; we_cnt = 0; ce_cnt = 0;
    a_w = '0; d_w = '0; oe_w = 1'b0;
    conf0 = bus_conflicts;
    @(negedge clk);
    push(a, d);
    exp_writes++;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      #1;
      if (fifo_rd_en === 1'b1) begin rd_cnt++; rd_idx = c; end
      if (sram_we_n === 1'b0) begin
        we_cnt++; we_idx = c; a_w = sram_addr; d_w = sram_dq_out; oe_w = sram_dq_oe;
      end
      if (sram_ce_n === 1'b0) begin
        if (ce_cnt == 0) ce_first = c;
        ce_cnt++;
      end
    end
    tests++;
    if (rd_cnt != 1 || we_cnt != 1 || ce_cnt != 3) begin
      fails++;
      $display("FAIL write_pulses: rd_en=%0d we_n_low=%0d ce_n_low=%0d required 1/1/3",
               rd_cnt, we_cnt, ce_cnt);
    end
    tests++;
    if (we_idx != rd_idx + 2 || ce_first != rd_idx + 1) begin
      fails++;
      $display("FAIL write_timing: pop@%0d ce@%0d we@%0d required ce=pop+1 we=pop+2",
               rd_idx, ce_first, we_idx);
    end
    tests++;
    if (a_w !== a || d_w !== d || oe_w !== 1'b1) begin
      fails++;
      $display("FAIL write_bus: addr=%h data=%h dq_oe=%b required %h/%h/1", a_w, d_w, oe_w, a, d);
    end
    tests++;
    if (write_count !== exp_count() || bus_conflicts != conf0) begin
      fails++;
      $display("FAIL write_count: got %h conflicts=%0d required %h/0",
               write_count, bus_conflicts - conf0, exp_count());
    end
  endtask

  task automatic test_video_read;
    @(negedge clk);
    vid_req = 1'b1;
    vid_addr = 17'h00010;
    sram_dq_in = 8'h00;
    #1;
    tests++;
    if (vid_grant !== 1'b1 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL read_grant: grant=%b rd_en=%b required 1/0", vid_grant, fifo_rd_en);
    end
    @(negedge clk);
    vid_req = 1'b0;
    vid_addr = 17'h1FFFF;
    sram_dq_in = 8'hC3;
    #1;
    tests++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, vid_valid} !== 5'b00100 ||
        sram_addr !== 17'h00010) begin
      fails++;
      $display("FAIL read_t1: ce,oe,we,dq_oe,valid=%b%b%b%b%b addr=%h required 00100/00010",
               sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, vid_valid, sram_addr);
    end
    @(negedge clk);
    #1;
    tests++;
    if (sram_oe_n !== 1'b0 || sram_dq_oe !== 1'b0 || vid_valid !== 1'b0) begin
      fails++;
      $display("FAIL read_t2: oe_n=%b dq_oe=%b valid=%b required 0/0/0",
               sram_oe_n, sram_dq_oe, vid_valid);
    end
    @(negedge clk);
    sram_dq_in = 8'h3C;
    #1;
    tests++;
    if (vid_valid !== 1'b1 || vid_data !== 8'hC3 || sram_oe_n !== 1'b1) begin
      fails++;
      $display("FAIL read_t3: valid=%b data=%h oe_n=%b required 1/c3/1",
               vid_valid, vid_data, sram_oe_n);
    end
    @(negedge clk);
    #1;
    tests++;
    if (vid_valid !== 1'b0) begin
      fails++;
      $display("FAIL read_valid_pulse: valid=%b required 0", vid_valid);
    end
  endtask

  task automatic test_priority;
    int rd_cnt;
    logic [16:0] a_w;
    rd_cnt = 0;
    a_w = '0;
    @(negedge clk);
    push(17'h00ABC, 8'h3E);
    exp_writes++;
    @(negedge clk);
    vid_req = 1'b1;
    vid_addr = 17'h00044;
    #1;
    tests++;
    if (vid_grant !== 1'b1 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL priority_grant: grant=%b rd_en=%b required 1/0", vid_grant, fifo_rd_en);
    end
    @(negedge clk);
    vid_req = 1'b0;
    #1;
    tests++;
    if (sram_oe_n !== 1'b0 || sram_addr !== 17'h00044) begin
      fails++;
      $display("FAIL priority_read_first: oe_n=%b addr=%h required 0/00044", sram_oe_n, sram_addr);
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      #1;
      if (fifo_rd_en === 1'b1) rd_cnt++;
      if (sram_we_n === 1'b0) a_w = sram_addr;
    end
    tests++;
    if (rd_cnt != 1 || a_w !== 17'h00ABC) begin
      fails++;
      $display("FAIL priority_write_follows: pops=%0d addr=%h required 1/00abc", rd_cnt, a_w);
    end
  endtask

  task automatic test_anti_starvation;
    logic [31:0] seq;
    logic [16:0] wa [2];
    logic [7:0]  wd [2];
    int n, nw;
    seq = '0; n = 0; nw = 0;
    wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    @(negedge clk);
    push(17'h00100, 8'h11);
    push(17'h00200, 8'h22);
    exp_writes += 2;
    @(negedge clk);
    vid_req = 1'b1;
    vid_addr = 17'h00020;
    sram_dq_in = 8'h99;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (vid_grant === 1'b1 && n < 32) n++;
      if (fifo_rd_en === 1'b1 && n < 32) begin seq[n] = 1'b1; n++; end
      if (sram_we_n === 1'b0 && nw < 2) begin wa[nw] = sram_addr; wd[nw] = sram_dq_out; nw++; end
      @(negedge clk);
    end
    vid_req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    tests++;
    if (n < 22 || seq[21:0] !== 22'h020100) begin
      fails++;
      $display("FAIL starvation_order: events=%0d pattern=%h required >=22/020100", n, seq[21:0]);
    end
    tests++;
    if (nw != 2 || wa[0] !== 17'h00100 || wa[1] !== 17'h00200 || wd[0] !== 8'h11 || wd[1] !== 8'h22) begin
      fails++;
      $display("FAIL starvation_writes: n=%0d %h/%h %h/%h required 2 00100/11 00200/22",
               nw, wa[0], wd[0], wa[1], wd[1]);
    end
    tests++;
    if (write_count !== exp_count() || bus_conflicts != 0) begin
      fails++;
      $display("FAIL starvation_count: got %h conflicts=%0d required %h/0",
               write_count, bus_conflicts, exp_count());
    end
  endtask

  task automatic test_back_to_back;
    int p0, p1, pops, wes;
    p0 = -1; p1 = -1; pops = 0; wes = 0;
    @(negedge clk);
    push(17'h01111, 8'hA1);
    push(17'h02222, 8'hB2);
    exp_writes += 2;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      #1;
      if (fifo_rd_en === 1'b1) begin
        if (pops == 0) p0 = c; else p1 = c;
        pops++;
      end
      if (sram_we_n === 1'b0) wes++;
    end
    tests++;
    if (pops != 2 || wes != 2 || p1 - p0 != 6) begin
      fails++;
      $display("FAIL back_to_back: pops=%0d we_low=%0d spacing=%0d required 2/2/6",
               pops, wes, p1 - p0);
    end
    tests++;
    if (write_count !== exp_count()) begin
      fails++;
      $display("FAIL back_to_back_count: got %h required %h", write_count, exp_count());
    end
  endtask

  task automatic test_reset_in_pulse;
    logic found;
    int activity;
    found = 1'b0;
    activity = 0;
    @(negedge clk);
    push(17'h0AAAA, 8'h77);
    for (int c = 0; c < 20; c++) begin
      if (!found) begin
        @(negedge clk);
        #1;
        if (sram_we_n === 1'b0) found = 1'b1;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL pulse_wait: we_n never low within 20 cycles, required a write pulse");
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, fifo_rd_en} !== 5'b11100 ||
        sram_addr !== 17'h0 || write_count !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid_pulse: we,ce,oe,dq_oe,rd_en=%b%b%b%b%b addr=%h wc=%h required 11100/0/0",
               sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, fifo_rd_en, sram_addr, write_count);
    end
    exp_writes = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (fifo_rd_en === 1'b1 || sram_we_n === 1'b0 || sram_ce_n === 1'b0) activity++;
    end
    tests++;
    if (activity != 0 || write_count !== 16'h0) begin
      fails++;
      $display("FAIL no_write_after_reset: active cycles=%0d wc=%h required 0/0", activity, write_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_write(17'h1ABCD, 8'h5A);
    test_video_read();
    test_priority();
    test_anti_starvation();
    test_back_to_back();
    test_reset_in_pulse();
    test_single_write(17'h00001, 8'hFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
